// File: rtl/wb_queue_if.sv
// Bundle of writeback request, register-file write and forwarding signals
// shared between the writeback queue and its user.
interface wb_queue_if;
    logic        i_reqValid;
    logic [2:0]  i_reqAddr;
    logic [15:0] i_reqData;
    logic        o_reqReady;
    logic        i_wStall;
    logic        o_wEn;
    logic [2:0]  o_wAddr;
    logic [15:0] o_wData;
    logic [2:0]  i_fwdAddr;
    logic        o_fwdHit;
    logic [15:0] o_fwdData;
    logic        o_spPending;
    logic [3:0]  o_count;

    modport slave (
        input  i_reqValid, i_reqAddr, i_reqData, i_wStall, i_fwdAddr,
        output o_reqReady, o_wEn, o_wAddr, o_wData, o_fwdHit, o_fwdData,
               o_spPending, o_count
    );

    modport master (
        output i_reqValid, i_reqAddr, i_reqData, i_wStall, i_fwdAddr,
        input  o_reqReady, o_wEn, o_wAddr, o_wData, o_fwdHit, o_fwdData,
               o_spPending, o_count
    );
endinterface

// File: rtl/wb_queue.sv
// Register-file writeback queue: circular FIFO draining into the write port,
// with youngest-match forwarding and a stack-pointer-pending flag.
module wb_queue #(
    parameter int DEPTH = 4
) (
    input logic       i_clk,
    input logic       i_rst,
    wb_queue_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] FULL = 4'(DEPTH);

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [3:0]    count;
    logic [2:0]    addr_mem [DEPTH];
    logic [15:0]   data_mem [DEPTH];
    logic          enq;
    logic          deq;
    logic          not_empty;
    logic [PW-1:0] slot;
    logic          hit;
    logic [15:0]   fwd_data;
    logic          sp;

    assign not_empty      = (count != 4'd0);
    assign bus.o_reqReady = (count != FULL);
    assign enq            = bus.i_reqValid & bus.o_reqReady;
    assign deq            = not_empty & ~bus.i_wStall;
    assign bus.o_wEn      = deq;
    assign bus.o_count    = count;
    assign bus.o_wAddr    = not_empty ? addr_mem[head] : 3'd0;
    assign bus.o_wData    = not_empty ? data_mem[head] : 16'd0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            head  <= '0;
            tail  <= '0;
            count <= 4'd0;
        end else begin
            if (enq) tail <= tail + PW'(1);
            if (deq) head <= head + PW'(1);
            case ({enq, deq})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge i_clk) begin
        if (enq && !i_rst) begin
            addr_mem[tail] <= bus.i_reqAddr;
            data_mem[tail] <= bus.i_reqData;
        end
    end

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        hit      = 1'b0;
        fwd_data = 16'd0;
        sp       = 1'b0;
        slot     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = head + PW'(i);
            if (4'(i) < count) begin
                if (addr_mem[slot] == bus.i_fwdAddr) begin
                    hit      = 1'b1;
                    fwd_data = data_mem[slot];
                end
                if (addr_mem[slot] == 3'b111) sp = 1'b1;
            end
        end
    end

    assign bus.o_fwdHit    = hit;
    assign bus.o_fwdData   = fwd_data;
    assign bus.o_spPending = sp;
endmodule
